// File: rtl/ex_stage.sv
// Execute stage: ALU, HI/LO forwarding and an iterative 32x32 shift-add multiplier.
// Define EX_FAST_MUL_EN to replace the multiplier FSM with a single-cycle combinational multiply.
module ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [2:0]  alusel_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  input  logic        mem_whilo_i,
  input  logic [31:0] mem_hi_i,
  input  logic [31:0] mem_lo_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        whilo_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        stallreq_o
);

  localparam int unsigned DW = 32;
  localparam int unsigned PW = 64;
  localparam int unsigned CW = 5;

  localparam logic [2:0] SEL_LOGIC = 3'b001;
  localparam logic [2:0] SEL_SHIFT = 3'b010;
  localparam logic [2:0] SEL_MOVE  = 3'b011;
  localparam logic [2:0] SEL_ARITH = 3'b100;
  localparam logic [2:0] SEL_MUL   = 3'b101;

  localparam logic [7:0] OP_AND   = 8'b0010_0100;
  localparam logic [7:0] OP_OR    = 8'b0010_0101;
  localparam logic [7:0] OP_XOR   = 8'b0010_0110;
  localparam logic [7:0] OP_NOR   = 8'b0010_0111;
  localparam logic [7:0] OP_SLL   = 8'b0111_1100;
  localparam logic [7:0] OP_SRL   = 8'b0000_0010;
  localparam logic [7:0] OP_SRA   = 8'b0000_0011;
  localparam logic [7:0] OP_MOVZ  = 8'b0000_1010;
  localparam logic [7:0] OP_MOVN  = 8'b0000_1011;
  localparam logic [7:0] OP_MFHI  = 8'b0001_0000;
  localparam logic [7:0] OP_MTHI  = 8'b0001_0001;
  localparam logic [7:0] OP_MFLO  = 8'b0001_0010;
  localparam logic [7:0] OP_MTLO  = 8'b0001_0011;
  localparam logic [7:0] OP_SLT   = 8'b0010_1010;
  localparam logic [7:0] OP_SLTU  = 8'b0010_1011;
  localparam logic [7:0] OP_ADD   = 8'b0010_0000;
  localparam logic [7:0] OP_ADDU  = 8'b0010_0001;
  localparam logic [7:0] OP_SUB   = 8'b0010_0010;
  localparam logic [7:0] OP_SUBU  = 8'b0010_0011;
  localparam logic [7:0] OP_ADDI  = 8'b0101_0101;
  localparam logic [7:0] OP_ADDIU = 8'b0101_0110;
  localparam logic [7:0] OP_CLZ   = 8'b1011_0000;
  localparam logic [7:0] OP_CLO   = 8'b1011_0001;
  localparam logic [7:0] OP_MULT  = 8'b0001_1000;
  localparam logic [7:0] OP_MULTU = 8'b0001_1001;
  localparam logic [7:0] OP_MUL   = 8'b1010_1001;

  logic [DW-1:0] hi_sel, lo_sel;
  logic [DW-1:0] logic_res, shift_res, move_res, arith_res;
  logic [DW-1:0] add_res, sub_res, clz_src;
  logic [5:0]    clz_cnt;
  logic          ov_add, ov_sub;
  logic          mul_op, mul_signed;
  logic [PW-1:0] prod_c;
  logic          mul_valid_c;
  logic          stall_c;

  assign hi_sel     = mem_whilo_i ? mem_hi_i : hi_i;
  assign lo_sel     = mem_whilo_i ? mem_lo_i : lo_i;
  assign mul_op     = (aluop_i == OP_MULT) || (aluop_i == OP_MULTU) || (aluop_i == OP_MUL);
  assign mul_signed = (aluop_i == OP_MULT) || (aluop_i == OP_MUL);

  // Per-class results; aluop selects within a class, alusel selects the class.
  always_comb begin
    logic_res = '0;
    shift_res = '0;
    move_res  = '0;
    arith_res = '0;
    add_res   = reg1_i + reg2_i;
    sub_res   = reg1_i - reg2_i;
    ov_add    = (reg1_i[31] == reg2_i[31]) && (add_res[31] != reg1_i[31]);
    ov_sub    = (reg1_i[31] != reg2_i[31]) && (sub_res[31] != reg1_i[31]);
    clz_src   = (aluop_i == OP_CLO) ? ~reg1_i : reg1_i;
    clz_cnt   = 6'd32;
    for (int i = 0; i < 32; i++) begin
      if (clz_src[i]) clz_cnt = 6'(31 - i);
    end
    case (aluop_i)
      OP_OR:  logic_res = reg1_i | reg2_i;
      OP_AND: logic_res = reg1_i & reg2_i;
      OP_XOR: logic_res = reg1_i ^ reg2_i;
      OP_NOR: logic_res = ~(reg1_i | reg2_i);
      default: ;
    endcase
    case (aluop_i)
      OP_SLL: shift_res = reg2_i << reg1_i[4:0];
      OP_SRL: shift_res = reg2_i >> reg1_i[4:0];
      OP_SRA: shift_res = DW'($signed(reg2_i) >>> reg1_i[4:0]);
      default: ;
    endcase
    case (aluop_i)
      OP_MFHI:          move_res = hi_sel;
      OP_MFLO:          move_res = lo_sel;
      OP_MOVN, OP_MOVZ: move_res = reg1_i;
      default: ;
    endcase
    case (aluop_i)
      OP_ADD, OP_ADDU, OP_ADDI, OP_ADDIU: arith_res = add_res;
      OP_SUB, OP_SUBU:                    arith_res = sub_res;
      OP_SLT:  arith_res = DW'($signed(reg1_i) < $signed(reg2_i));
      OP_SLTU: arith_res = DW'(reg1_i < reg2_i);
      OP_CLZ, OP_CLO: arith_res = DW'(clz_cnt);
      default: ;
    endcase
  end

`ifdef EX_FAST_MUL_EN
  logic [PW-1:0] op1_ext, op2_ext;

  // Single-cycle multiply; sign extension picks the signed or unsigned interpretation.
  always_comb begin
    op1_ext     = mul_signed ? {{DW{reg1_i[31]}}, reg1_i} : {{DW{1'b0}}, reg1_i};
    op2_ext     = mul_signed ? {{DW{reg2_i[31]}}, reg2_i} : {{DW{1'b0}}, reg2_i};
    prod_c      = op1_ext * op2_ext;
    mul_valid_c = 1'b1;
    stall_c     = 1'b0;
  end
`else
  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} mul_state_e;

  mul_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] acc_q, acc_d;
  logic [DW-1:0] mcand_q, mcand_d;
  logic [DW-1:0] mplier_q, mplier_d;
  logic          neg_q, neg_d;

  // Magnitudes are multiplied unsigned; the sign is reapplied when the product is presented.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    stall_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mul_op) begin
          stall_c  = 1'b1;
          state_d  = ST_BUSY;
          cnt_d    = '0;
          acc_d    = '0;
          mcand_d  = (mul_signed && reg1_i[31]) ? DW'(~reg1_i + 1'b1) : reg1_i;
          mplier_d = (mul_signed && reg2_i[31]) ? DW'(~reg2_i + 1'b1) : reg2_i;
          neg_d    = mul_signed && (reg1_i[31] ^ reg2_i[31]);
        end
      end
      ST_BUSY: begin
        stall_c = 1'b1;
        if (mplier_q[cnt_q]) acc_d = acc_q + (PW'(mcand_q) << cnt_q);
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(31)) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    prod_c      = neg_q ? (~acc_q + PW'(1)) : acc_q;
    mul_valid_c = (state_q == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
    end
  end
`endif

  // Output mux; stall and reset suppress every write.
  always_comb begin
    wd_o       = wd_i;
    wreg_o     = wreg_i;
    wdata_o    = '0;
    whilo_o    = 1'b0;
    hi_o       = '0;
    lo_o       = '0;
    stallreq_o = stall_c;
    case (alusel_i)
      SEL_LOGIC: wdata_o = logic_res;
      SEL_SHIFT: wdata_o = shift_res;
      SEL_MOVE:  wdata_o = move_res;
      SEL_ARITH: wdata_o = arith_res;
      SEL_MUL:   wdata_o = prod_c[DW-1:0];
      default: ;
    endcase
    case (aluop_i)
      OP_ADD, OP_ADDI: if (ov_add) wreg_o = 1'b0;
      OP_SUB:          if (ov_sub) wreg_o = 1'b0;
      OP_MTHI: begin
        whilo_o = 1'b1;
        hi_o    = reg1_i;
        lo_o    = lo_sel;
      end
      OP_MTLO: begin
        whilo_o = 1'b1;
        hi_o    = hi_sel;
        lo_o    = reg1_i;
      end
      OP_MULT, OP_MULTU: begin
        wreg_o  = 1'b0;
        whilo_o = mul_valid_c;
        hi_o    = prod_c[PW-1:DW];
        lo_o    = prod_c[DW-1:0];
      end
      default: ;
    endcase
    if (stall_c) begin
      wreg_o  = 1'b0;
      whilo_o = 1'b0;
    end
    if (rst) begin
      wd_o       = '0;
      wreg_o     = 1'b0;
      wdata_o    = '0;
      whilo_o    = 1'b0;
      hi_o       = '0;
      lo_o       = '0;
      stallreq_o = 1'b0;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed corner cases plus randomized ops against an arithmetic reference.
module tb_ex_stage;

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_AND   = 8'b0010_0100;
  localparam logic [7:0] OP_OR    = 8'b0010_0101;
  localparam logic [7:0] OP_XOR   = 8'b0010_0110;
  localparam logic [7:0] OP_NOR   = 8'b0010_0111;
  localparam logic [7:0] OP_SLL   = 8'b0111_1100;
  localparam logic [7:0] OP_SRL   = 8'b0000_0010;
  localparam logic [7:0] OP_SRA   = 8'b0000_0011;
  localparam logic [7:0] OP_MOVZ  = 8'b0000_1010;
  localparam logic [7:0] OP_MOVN  = 8'b0000_1011;
  localparam logic [7:0] OP_MFHI  = 8'b0001_0000;
  localparam logic [7:0] OP_MTHI  = 8'b0001_0001;
  localparam logic [7:0] OP_MFLO  = 8'b0001_0010;
  localparam logic [7:0] OP_MTLO  = 8'b0001_0011;
  localparam logic [7:0] OP_SLT   = 8'b0010_1010;
  localparam logic [7:0] OP_SLTU  = 8'b0010_1011;
  localparam logic [7:0] OP_ADD   = 8'b0010_0000;
  localparam logic [7:0] OP_ADDU  = 8'b0010_0001;
  localparam logic [7:0] OP_SUB   = 8'b0010_0010;
  localparam logic [7:0] OP_SUBU  = 8'b0010_0011;
  localparam logic [7:0] OP_ADDI  = 8'b0101_0101;
  localparam logic [7:0] OP_ADDIU = 8'b0101_0110;
  localparam logic [7:0] OP_CLZ   = 8'b1011_0000;
  localparam logic [7:0] OP_CLO   = 8'b1011_0001;
  localparam logic [7:0] OP_MULT  = 8'b0001_1000;
  localparam logic [7:0] OP_MULTU = 8'b0001_1001;
  localparam logic [7:0] OP_MUL   = 8'b1010_1001;

  localparam int NC = 24;
  localparam logic [7:0] COMB_OPS [0:NC-1] = '{
    OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLL, OP_SRL, OP_SRA, OP_MOVZ, OP_MOVN,
    OP_MFHI, OP_MTHI, OP_MFLO, OP_MTLO, OP_SLT, OP_SLTU, OP_ADD, OP_ADDU,
    OP_SUB, OP_SUBU, OP_ADDI, OP_ADDIU, OP_CLZ, OP_CLO, 8'hFF};

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  aluop_i;
  logic [2:0]  alusel_i;
  logic [31:0] reg1_i, reg2_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] hi_i, lo_i;
  logic        mem_whilo_i;
  logic [31:0] mem_hi_i, mem_lo_i;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        whilo_o;
  logic [31:0] hi_o, lo_o;
  logic        stallreq_o;

  int tests = 0;
  int fails = 0;

  ex_stage dut (
    .clk(clk), .rst(rst), .aluop_i(aluop_i), .alusel_i(alusel_i),
    .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i),
    .hi_i(hi_i), .lo_i(lo_i), .mem_whilo_i(mem_whilo_i),
    .mem_hi_i(mem_hi_i), .mem_lo_i(mem_lo_i),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .whilo_o(whilo_o),
    .hi_o(hi_o), .lo_o(lo_o), .stallreq_o(stallreq_o));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] sel_of(input logic [7:0] op);
    case (op)
      OP_AND, OP_OR, OP_XOR, OP_NOR:            return 3'b001;
      OP_SLL, OP_SRL, OP_SRA:                   return 3'b010;
      OP_MFHI, OP_MFLO, OP_MOVN, OP_MOVZ:       return 3'b011;
      OP_SLT, OP_SLTU, OP_ADD, OP_ADDU, OP_SUB, OP_SUBU,
      OP_ADDI, OP_ADDIU, OP_CLZ, OP_CLO:        return 3'b100;
      OP_MUL:                                   return 3'b101;
      default:                                  return 3'b000;
    endcase
  endfunction

  function automatic int lead_count(input logic [31:0] v, input logic bitval);
    int n = 0;
    while (n < 32 && v[31-n] == bitval) n++;
    return n;
  endfunction

  // Reference for single-cycle ops, written from the instruction semantics.
  function automatic void ref_model(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                                    input logic wr, input logic [31:0] hs, input logic [31:0] ls,
                                    output logic [31:0] wdata, output logic wreg, output logic whilo,
                                    output logic [31:0] hi, output logic [31:0] lo);
    int ia = a;
    int ib = b;
    longint s;
    int t;
    wdata = 0; wreg = wr; whilo = 0; hi = 0; lo = 0;
    case (op)
      OP_AND:  wdata = a & b;
      OP_OR:   wdata = a | b;
      OP_XOR:  wdata = a ^ b;
      OP_NOR:  wdata = ~(a | b);
      OP_SLL:  wdata = b << a[4:0];
      OP_SRL:  wdata = b >> a[4:0];
      OP_SRA:  wdata = ib >>> a[4:0];
      OP_ADDU, OP_ADDIU: wdata = a + b;
      OP_SUBU: wdata = a - b;
      OP_ADD, OP_ADDI, OP_SUB: begin
        s = (op == OP_SUB) ? longint'(ia) - longint'(ib) : longint'(ia) + longint'(ib);
        t = s[31:0];
        wdata = t;
        if (longint'(t) != s) wreg = 0;
      end
      OP_SLT:  wdata = (ia < ib) ? 1 : 0;
      OP_SLTU: wdata = (a < b) ? 1 : 0;
      OP_CLZ:  wdata = lead_count(a, 1'b0);
      OP_CLO:  wdata = lead_count(a, 1'b1);
      OP_MFHI: wdata = hs;
      OP_MFLO: wdata = ls;
      OP_MOVN, OP_MOVZ: wdata = a;
      OP_MTHI: begin whilo = 1; hi = a; lo = ls; end
      OP_MTLO: begin whilo = 1; hi = hs; lo = a; end
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic drive(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b, input logic wr);
    aluop_i  = op;
    alusel_i = sel_of(op);
    reg1_i   = a;
    reg2_i   = b;
    wreg_i   = wr;
    wd_i     = 5'($urandom);
  endtask

  task automatic run_comb(input string tag, input logic [7:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic wr);
    logic [31:0] e_wdata, e_hi, e_lo;
    logic        e_wreg, e_whilo;
    drive(op, a, b, wr);
    #2;
    ref_model(op, a, b, wr, mem_whilo_i ? mem_hi_i : hi_i, mem_whilo_i ? mem_lo_i : lo_i,
              e_wdata, e_wreg, e_whilo, e_hi, e_lo);
    check({tag, ".wdata"}, 64'(wdata_o), 64'(e_wdata));
    check({tag, ".wreg"},  64'(wreg_o),  64'(e_wreg));
    check({tag, ".whilo"}, 64'(whilo_o), 64'(e_whilo));
    check({tag, ".hilo"},  {hi_o, lo_o}, {e_hi, e_lo});
    check({tag, ".wd"},    64'(wd_o),    64'(wd_i));
    check({tag, ".stall"}, 64'(stallreq_o), 64'(0));
  endtask

  // Launches a multiply at a negedge and counts stall cycles until the result appears.
  task automatic run_mul(input string tag, input logic [7:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic wr);
    int stalls = 0;
    logic leak = 0;
    int ia = a;
    int ib = b;
    logic [63:0] p;
    @(negedge clk);
    drive(op, a, b, wr);
    for (int i = 0; i < 100; i++) begin
      #1;
      if (!stallreq_o) break;
      stalls++;
      if (wreg_o || whilo_o) leak = 1;
      @(negedge clk);
    end
    p = (op == OP_MULTU) ? {32'h0, a} * {32'h0, b} : 64'(longint'(ia) * longint'(ib));
    check({tag, ".stalls"}, 64'(stalls), 64'(33));
    check({tag, ".quiet_during_stall"}, 64'(leak), 64'(0));
    if (op == OP_MUL) begin
      check({tag, ".wdata"}, 64'(wdata_o), 64'(p[31:0]));
      check({tag, ".wreg"},  64'(wreg_o),  64'(wr));
      check({tag, ".whilo"}, 64'(whilo_o), 64'(0));
    end else begin
      check({tag, ".hilo"},  {hi_o, lo_o}, p);
      check({tag, ".whilo"}, 64'(whilo_o), 64'(1));
      check({tag, ".wreg"},  64'(wreg_o),  64'(0));
    end
    drive(OP_NOP, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    drive(OP_OR, 32'h1234_5678, 32'h0F0F_0000, 1'b1);
    hi_i = 32'h1111; lo_i = 32'h3333;
    mem_whilo_i = 1'b0; mem_hi_i = 32'h2222; mem_lo_i = 32'h4444;
    #3;
    check("reset.outputs", {27'(0), wd_o, wreg_o, whilo_o, stallreq_o}, 64'(0));
    check("reset.data", {wdata_o, hi_o ^ lo_o}, 64'(0));
    @(negedge clk);
    rst = 1'b0;

    run_comb("add_ovf", OP_ADD, 32'h7FFF_FFFF, 32'h1, 1'b1);
    check("add_ovf.const", {31'(0), wreg_o, wdata_o}, {31'(0), 1'b0, 32'h8000_0000});
    run_comb("addu_wrap", OP_ADDU, 32'h7FFF_FFFF, 32'h1, 1'b1);
    check("addu_wrap.wreg", 64'(wreg_o), 64'(1));
    mem_whilo_i = 1'b1;
    run_comb("mfhi_fwd", OP_MFHI, 0, 0, 1'b1);
    check("mfhi_fwd.const", 64'(wdata_o), 64'h2222);
    mem_whilo_i = 1'b0;
    run_comb("mthi", OP_MTHI, 32'hABCD_0001, 0, 1'b0);
    run_comb("clz0", OP_CLZ, 32'h0, 0, 1'b1);
    check("clz0.const", 64'(wdata_o), 64'd32);
    run_comb("clo4", OP_CLO, 32'hF000_0000, 0, 1'b1);
    check("clo4.const", 64'(wdata_o), 64'd4);
    run_comb("sra", OP_SRA, 32'd4, 32'h8000_0000, 1'b1);
    check("sra.const", 64'(wdata_o), 64'hF800_0000);
    run_comb("unknown", 8'hFF, 32'hDEAD_BEEF, 32'h1, 1'b1);

    run_mul("mult_neg", OP_MULT, 32'hFFFF_FFFE, 32'd3, 1'b1);
    check("mult_neg.const", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFA);
    run_mul("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    check("multu_max.const", {hi_o, lo_o}, 64'hFFFF_FFFE_0000_0001);

    // Abort a multiply mid-flight at counter value 10.
    @(negedge clk);
    drive(OP_MULT, 32'd1234, 32'd5678, 1'b1);
    for (int i = 0; i < 11; i++) @(negedge clk);
    #1;
    check("abort.stall_before", 64'(stallreq_o), 64'(1));
    rst = 1'b1;
    #1;
    check("abort.stall", 64'(stallreq_o), 64'(0));
    check("abort.writes", {62'(0), whilo_o, wreg_o}, 64'(0));
    drive(OP_NOP, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    run_mul("mul_after_abort", OP_MUL, 32'd5, 32'd7, 1'b1);
    check("mul_after_abort.const", 64'(wdata_o), 64'd35);

    for (int n = 0; n < 80; n++) begin
      hi_i = $urandom; lo_i = $urandom;
      mem_hi_i = $urandom; mem_lo_i = $urandom;
      mem_whilo_i = 1'($urandom);
      run_comb("rand", COMB_OPS[$urandom_range(0, NC-1)], rnd_operand(), rnd_operand(), 1'($urandom));
    end
    for (int n = 0; n < 6; n++) begin
      case (n % 3)
        0: run_mul("rand_mult", OP_MULT, rnd_operand(), rnd_operand(), 1'b1);
        1: run_mul("rand_multu", OP_MULTU, rnd_operand(), rnd_operand(), 1'b1);
        default: run_mul("rand_mul", OP_MUL, rnd_operand(), rnd_operand(), 1'($urandom));
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 clk  in  1  sole clock, rising edge.
REQ-002 rst  in  1  asynchronous, active-high reset.
REQ-003 aluop_i  in  8  operation code from the ID/EX register, encoding per defines.v.
REQ-004 alusel_i  in  3  result class: NOP/LOGIC/SHIFT/MOVE/ARITHMETIC/MUL.
REQ-005 reg1_i, reg2_i  in  32 each  source operands, forwarded or immediate.
REQ-006 wd_i  in  5  destination GPR.
REQ-007 wreg_i  in  1  GPR write request.
REQ-008 hi_i, lo_i  in  32 each  committed HI/LO.
REQ-009 mem_whilo_i  in  1  MEM stage writes HI/LO.
REQ-010 mem_hi_i, mem_lo_i  in  32 each  HI/LO values in flight in MEM.
REQ-011 wd_o  out  5  destination GPR, equal to wd_i.
REQ-012 wreg_o  out  1  GPR write enable.
REQ-013 wdata_o  out  32  GPR write data.
REQ-014 whilo_o  out  1  HI/LO write enable.
REQ-015 hi_o, lo_o  out  32 each  HI/LO write data.
REQ-016 stallreq_o  out  1  hold the PC, IF/ID and ID/EX registers this cycle.

Function
REQ-020 Logic ops SHALL produce OR/AND/XOR/NOR of reg1_i and reg2_i.
REQ-021 SLL/SRL/SRA SHALL shift reg2_i by reg1_i[4:0]. SRA SHALL sign-fill.
REQ-022 ADD/ADDI/ADDU/ADDIU/SUB/SUBU SHALL compute 32-bit wrap results.
REQ-023 ADD/ADDI/SUB SHALL force wreg_o=0 on signed overflow.
REQ-024 SLT SHALL compare signed and SLTU unsigned; the result SHALL be 0 or 1.
REQ-025 CLZ/CLO SHALL count leading zeros/ones of reg1_i, giving 0..32.
REQ-026 HI/LO source SHALL be mem_hi_i/mem_lo_i when mem_whilo_i=1, else hi_i/lo_i.
REQ-027 MFHI/MFLO SHALL output the selected HI/LO.
REQ-028 MOVN/MOVZ SHALL output reg1_i with wreg_o=wreg_i.
REQ-029 MTHI SHALL set whilo_o=1, hi_o=reg1_i and lo_o=selected LO. MTLO is the mirror case.
REQ-030 MULT/MULTU/MUL SHALL use an iterative shift-add multiplier FSM with states IDLE, BUSY and DONE.
REQ-031 IDLE to BUSY SHALL occur when a multiply aluop is present. Operands SHALL be latched on that edge (signed ops latch magnitudes plus the result sign), and a 5-bit counter SHALL clear.
REQ-032 BUSY SHALL add one multiplicand-shifted partial product per cycle into a 64-bit accumulator, then increment the counter. BUSY to DONE SHALL occur when counter=31.
REQ-033 DONE SHALL apply two's-complement negation to the product if the sign is set, present the result, then return to IDLE on the next edge.
REQ-034 stallreq_o SHALL equal 1 in IDLE with a multiply aluop present, and 1 throughout BUSY. It SHALL be 0 in DONE, giving 33 stall cycles and the result on cycle 34.
REQ-035 MUL SHALL write product[31:0] to wdata_o with wreg_o=wreg_i.
REQ-036 MULT/MULTU SHALL set whilo_o=1 with {hi_o,lo_o}=product and wreg_o=0.
REQ-037 Outputs SHALL hold wreg_o=0 and whilo_o=0 while stallreq_o=1.
REQ-038 An unknown aluop SHALL give wdata_o=0, whilo_o=0 and wreg_o=wreg_i.
REQ-039 A multiply present in DONE SHALL NOT restart the FSM. A new multiply starts only from IDLE.

Reset
REQ-050 rst=1 SHALL set the FSM to IDLE and clear the counter, accumulator and latched operands.
REQ-051 While rst=1 all outputs SHALL be 0, including stallreq_o. Reset during BUSY SHALL abort with no HI/LO or GPR write.

Configuration
REQ-060 With EX_FAST_MUL_EN defined, the FSM SHALL be omitted. MUL/MULT/MULTU SHALL complete combinationally in one cycle, and stallreq_o SHALL be held 0.
REQ-061 Without EX_FAST_MUL_EN, REQ-030..REQ-039 SHALL apply.

Verification
REQ-070 ADD with reg1=0x7FFFFFFF and reg2=1 -> wdata_o=0x80000000 and wreg_o=0; ADDU with the same operands -> wreg_o=1.
REQ-071 MULT with reg1=0xFFFFFFFE (-2) and reg2=3 -> stallreq_o high for 33 cycles, then whilo_o=1, hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFA.
REQ-072 MULTU with reg1=reg2=0xFFFFFFFF -> after the stall, hi_o=0xFFFFFFFE and lo_o=0x00000001.
REQ-073 MFHI with hi_i=0x1111 and mem_whilo_i=1, mem_hi_i=0x2222 -> wdata_o=0x2222.
REQ-074 rst pulsed at BUSY counter=10 -> stallreq_o=0 and whilo_o=0 immediately; the next MUL of 5 and 7 -> wdata_o=35.
REQ-075 CLZ with reg1=0 -> 32; CLO with reg1=0xF0000000 -> 4; SRA of 0x80000000 by 4 -> 0xF8000000.
